// File: rtl/pausible_pkg.sv
// rtl/pausible_pkg.sv - shared types and constants for the pausible-clock ports
// Contents: transfer FSM state encoding, xfer counter width, default grant synchronizer depth.
package pausible_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int XFER_W              = 16;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/pausible_tx_port_if.sv
// rtl/pausible_tx_port_if.sv - upstream valid/ready word interface
// Signals: in_valid (word offered), in_ready (sink can accept), in_data (word).
// Modports: master drives words, slave (the tx port) accepts them.
interface pausible_tx_port_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - reset-clearing multi-flop synchronizer for one asynchronous bit
// Ports: clock, rst (sync active-high, clears every stage), d (async input), q (last stage).
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clock) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pausible_tx_port.sv
// rtl/pausible_tx_port.sv - FIFO-buffered sender into a pausible-clock domain
// Ports: clock, rst (sync active-high); up (slave valid/ready word input);
//        req (registered request to the pausible clock), grant (async grant back);
//        data_out (bundled word, stable while req/grant handshake is open);
//        busy (transfer in progress), xfer_count (completed transfers, wraps).
module pausible_tx_port
    import pausible_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int HOLD        = 2
) (
    input  logic                clock,
    input  logic                rst,
    pausible_tx_port_if.slave   up,
    output logic                req,
    input  logic                grant,
    output logic [WIDTH-1:0]    data_out,
    output logic                busy,
    output logic [XFER_W-1:0]   xfer_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD - 1);

    logic             grant_s;

    state_t           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             req_q, req_d;
    logic             load_data;
    logic             pop;
    logic             push;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count_q, count_d;
    logic             in_ready_q;
    logic [WIDTH-1:0] data_q;
    logic [XFER_W-1:0] xfer_q;

    sync_ff #(.STAGES(SYNC_STAGES)) u_grant_sync (
        .clock (clock),
        .rst   (rst),
        .d     (grant),
        .q     (grant_s)
    );

    // State register; req is flopped from the next state so it never glitches.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            req_q   <= req_d;
        end
    end

    // Next-state logic. A grant still high from an earlier handshake (or from
    // before reset) blocks a new request until it is seen low.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        load_data = 1'b0;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0 && !grant_s) begin
                    state_d   = ST_REQ;
                    load_data = 1'b1;
                end
            end
            ST_REQ: begin
                if (grant_s) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_INIT;
                end
            end
            ST_HOLD: begin
                if (hold_q == '0) begin
                    state_d = ST_RELEASE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!grant_s) begin
                    state_d = ST_IDLE;
                    pop     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        req_d = (state_d == ST_REQ) || (state_d == ST_HOLD);
        busy  = (state_q != ST_IDLE);
    end

    // FIFO: no bypass, push gated by the registered ready so a full FIFO
    // refuses even on the pop edge.
    assign push    = up.in_valid && in_ready_q;
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= up.in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q    <= count_d;
            in_ready_q <= (count_d != CW'(DEPTH));
        end
    end

    // Bundled data is captured once per transfer and held until the pop.
    always_ff @(posedge clock) begin
        if (rst) begin
            data_q <= '0;
            xfer_q <= '0;
        end else begin
            if (load_data) begin
                data_q <= mem[rd_ptr];
            end
            if (pop) begin
                xfer_q <= xfer_q + XFER_W'(1);
            end
        end
    end

    assign up.in_ready = in_ready_q;
    assign req         = req_q;
    assign data_out    = data_q;
    assign xfer_count  = xfer_q;

endmodule

// File: tb/tb_pausible_tx_port.sv
// tb/tb_pausible_tx_port.sv - self-checking bench for pausible_tx_port
module tb_pausible_tx_port;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int S     = 2;
    localparam int H     = 2;

    logic              clock = 1'b0;
    logic              rst   = 1'b1;
    logic              loop  = 1'b0;
    logic              grant_drv = 1'b0;
    logic              grant;
    logic              req;
    logic              busy;
    logic [WIDTH-1:0]  data_out;
    logic [15:0]       xfer_count;

    int n_cmp = 0;
    int n_bad = 0;

    pausible_tx_port_if #(.WIDTH(WIDTH)) up ();

    assign grant = loop ? req : grant_drv;

    pausible_tx_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(S), .HOLD(H)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .up         (up),
        .req        (req),
        .grant      (grant),
        .data_out   (data_out),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a word queue, a grant delay line, and the
    // request/hold/release handshake described as "in flight" bookkeeping.
    logic [WIDTH-1:0] q_m[$];
    logic [S-1:0]     hist_m = '0;
    bit               in_flight_m = 0;
    bit               req_m = 0;
    bit               granted_m = 0;
    int               hold_left_m = 0;
    logic [WIDTH-1:0] dout_m = '0;
    bit               ready_m = 1;
    int               xfers_m = 0;
    logic [15:0]      cnt_base = 16'h0000;

    always @(posedge clock) begin
        bit               gs;
        bit               do_push;
        logic [WIDTH-1:0] pd;
        gs      = hist_m[S-1];
        do_push = up.in_valid && ready_m;
        pd      = up.in_data;
        if (rst) begin
            q_m.delete();
            hist_m      = '0;
            in_flight_m = 0;
            req_m       = 0;
            granted_m   = 0;
            dout_m      = '0;
            ready_m     = 1;
            xfers_m     = 0;
        end else begin
            hist_m = {hist_m[S-2:0], grant};
            if (!in_flight_m) begin
                if (q_m.size() != 0 && !gs) begin
                    in_flight_m = 1;
                    req_m       = 1;
                    granted_m   = 0;
                    dout_m      = q_m[0];
                end
            end else if (req_m && !granted_m) begin
                if (gs) begin
                    granted_m   = 1;
                    hold_left_m = H - 1;
                end
            end else if (req_m) begin
                if (hold_left_m == 0) req_m = 0;
                else hold_left_m--;
            end else if (!gs) begin
                void'(q_m.pop_front());
                xfers_m++;
                in_flight_m = 0;
            end
            if (do_push) q_m.push_back(pd);
            ready_m = (q_m.size() < DEPTH);
        end
    end

    always @(negedge clock) begin
        logic [15:0] exp_cnt;
        exp_cnt = cnt_base + 16'(xfers_m);
        chk("m_req",      32'(req),         32'(req_m));
        chk("m_busy",     32'(busy),        32'(in_flight_m));
        chk("m_in_ready", 32'(up.in_ready), 32'(ready_m));
        chk("m_data_out", 32'(data_out),    32'(dout_m));
        chk("m_xfer",     32'(xfer_count),  32'(exp_cnt));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        up.in_valid = 1'b1;
        up.in_data  = d;
        tick();
        up.in_valid = 1'b0;
    endtask

    initial begin
        int               reqcnt;
        int               first_req;
        int               last_busy;
        bit               prev_req;
        bit               prev_ready;
        bit               seen_pop;
        bit               any_req;
        bit               seen_ffff;
        bit               seen_wrap;
        logic [15:0]      prev_cnt;
        logic [WIDTH-1:0] got[$];
        logic [WIDTH-1:0] sent[4];

        up.in_valid = 1'b0;
        up.in_data  = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_req",      32'(req),         32'd0);
        chk("rst_in_ready", 32'(up.in_ready), 32'd1);
        chk("rst_busy",     32'(busy),        32'd0);
        chk("rst_data_out", 32'(data_out),    32'd0);
        chk("rst_xfer",     32'(xfer_count),  32'd0);
        rst = 1'b0;
        tick();

        // Single loopback transfer of 0xA5
        loop = 1'b1;
        push(8'hA5);
        reqcnt = 0; first_req = -1; last_busy = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (req) begin
                reqcnt++;
                if (first_req < 0) first_req = i;
                chk("t1_data_held", 32'(data_out), 32'h0000_00A5);
            end
            if (busy) last_busy = i;
        end
        chk("t1_req_cycles", 32'(reqcnt),     32'd5);
        chk("t1_first_req",  32'(first_req),  32'd1);
        chk("t1_last_busy",  32'(last_busy),  32'd8);
        chk("t1_xfer",       32'(xfer_count), 32'd1);

        // Fill the FIFO with grant tied low
        loop = 1'b0;
        grant_drv = 1'b0;
        sent[0] = 8'h11; sent[1] = 8'h22; sent[2] = 8'h33; sent[3] = 8'h44;
        for (int k = 0; k < 4; k++) push(sent[k]);
        chk("t2_full_ready", 32'(up.in_ready), 32'd0);
        chk("t2_req_stuck",  32'(req),         32'd1);
        up.in_valid = 1'b1;
        up.in_data  = 8'h55;
        repeat (5) tick();
        up.in_valid = 1'b0;
        repeat (10) tick();
        chk("t2_refused_ready", 32'(up.in_ready), 32'd0);
        chk("t2_req_still",     32'(req),         32'd1);
        chk("t2_busy",          32'(busy),        32'd1);
        chk("t2_no_pop",        32'(xfer_count),  32'd1);

        // Drain via loopback
        loop = 1'b1;
        prev_req = req; prev_ready = up.in_ready; prev_cnt = xfer_count; seen_pop = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (req && !prev_req) got.push_back(data_out);
            if (xfer_count != prev_cnt && !seen_pop) begin
                seen_pop = 1;
                chk("t3_ready_before_pop", 32'(prev_ready),   32'd0);
                chk("t3_ready_after_pop",  32'(up.in_ready),  32'd1);
            end
            prev_req = req; prev_ready = up.in_ready; prev_cnt = xfer_count;
        end
        chk("t3_xfer",  32'(xfer_count), 32'd5);
        chk("t3_nwords", 32'(got.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < got.size()) chk("t3_order", 32'(got[k]), 32'(sent[k + 1]));
        end

        // Grant held high through reset, released 7 cycles afterwards
        loop = 1'b0;
        grant_drv = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        any_req = 0;
        repeat (3) begin tick(); if (req) any_req = 1; end
        push(8'h3C);
        if (req) any_req = 1;
        repeat (3) begin tick(); if (req) any_req = 1; end
        chk("t4_no_req_while_granted", 32'(any_req), 32'd0);
        grant_drv = 1'b0;
        loop = 1'b1;
        tick(); chk("t4_req_g1", 32'(req), 32'd0);
        tick(); chk("t4_req_g2", 32'(req), 32'd0);
        tick(); chk("t4_req_g3", 32'(req), 32'd1);
        chk("t4_data", 32'(data_out), 32'h0000_003C);
        repeat (12) tick();
        chk("t4_xfer", 32'(xfer_count), 32'd1);

        // Reset during HOLD
        push(8'h77);
        tick();
        chk("t5_req_up", 32'(req), 32'd1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_req",      32'(req),         32'd0);
        chk("t5_busy",     32'(busy),        32'd0);
        chk("t5_in_ready", 32'(up.in_ready), 32'd1);
        chk("t5_xfer",     32'(xfer_count),  32'd0);
        any_req = 0;
        repeat (15) begin tick(); if (req) any_req = 1; end
        chk("t5_fifo_empty", 32'(any_req),    32'd0);
        chk("t5_xfer_after", 32'(xfer_count), 32'd0);

        // Counter wrap, starting two below the top
        force dut.xfer_q = 16'hFFFE;
        cnt_base = 16'hFFFE;
        tick();
        release dut.xfer_q;
        push(8'h01); push(8'h02); push(8'h03);
        seen_ffff = 0; seen_wrap = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (xfer_count == 16'hFFFF) seen_ffff = 1;
            if (xfer_count == 16'h0000 && seen_ffff) seen_wrap = 1;
        end
        chk("t6_wrap",  32'(seen_wrap),  32'd1);
        chk("t6_final", 32'(xfer_count), 32'h0000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
